rotation_seq_ctrl: RTL and testbench
====================================

ROTATION_SEQ_CTRL -- requirements
Module: rotation_seq_ctrl

Interface
REQ-001 SHALL have parameter ANGLE_STEPS, default 71, number of discrete angle positions (angle range 0..70).
REQ-002 SHALL have parameter FRAMES_PER_STEP, default 4, frame syncs per auto-rotate step (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles to wait for CORDIC done.
REQ-004 SHALL have port CLK input 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N input 1: synchronous, active-low reset.
REQ-006 SHALL have port iAUTO input 1: 1 = auto-rotate, 0 = manual angle.
REQ-007 SHALL have port iTHETA input 7: manual angle, or auto step size.
REQ-008 SHALL have port iFRAME_SYNC input 1: one-cycle pulse at the end of each display frame.
REQ-009 SHALL have port iCORDIC_DONE input 1: one-cycle pulse when the CORDIC results are valid.
REQ-010 SHALL have ports iCORDIC_COS and iCORDIC_SIN input 16 each: signed Q8 results, valid with iCORDIC_DONE.
REQ-011 SHALL have port oCORDIC_START output 1: one-cycle request pulse to the CORDIC.
REQ-012 SHALL have port oCORDIC_ANGLE output 7: angle for the request, held stable from START until the transaction ends.
REQ-013 SHALL have ports oCOS and oSIN output 16 each: committed signed Q8 coefficients feeding the pixel-map datapath.
REQ-014 SHALL have port oANGLE output 7: committed angle.
REQ-015 SHALL have ports oBUSY, oUPDATED and oERR output 1 each: transaction in flight; one-cycle commit pulse; one-cycle timeout pulse.

Function
REQ-016 SHALL reduce iTHETA modulo ANGLE_STEPS with one conditional subtract (iTHETA>=71 -> iTHETA-71), giving thetaN.
REQ-017 SHALL, when in manual mode and IDLE, dispatch a request whenever thetaN != oANGLE, with target = thetaN.
REQ-018 SHALL, in auto mode, count iFRAME_SYNC pulses 0..FRAMES_PER_STEP-1 and wrap; each wrap raises a step event.
REQ-019 SHALL hold a single-deep pending flag for step events; an event arriving while pending is already set is coalesced (dropped).
REQ-020 SHALL, on dispatching an auto request, set target = (oANGLE + thetaN) mod 71 using one conditional subtract (sum max 140), and clear pending.
REQ-021 SHALL treat a step size thetaN of 0 as a no-op: clear pending and dispatch nothing.
REQ-022 SHALL implement FSM IDLE -> START -> WAIT -> HOLD -> IDLE.
REQ-023 SHALL assert oCORDIC_START for exactly the one START cycle, latch the target on oCORDIC_ANGLE, and then move to WAIT.
REQ-024 SHALL, in WAIT, capture iCORDIC_COS/SIN into shadow registers on iCORDIC_DONE and then move to HOLD.
REQ-025 SHALL, if no done pulse arrives within TIMEOUT cycles of START, pulse oERR, discard the result, leave committed outputs unchanged, and return to IDLE.
REQ-026 SHALL ignore iCORDIC_DONE outside WAIT.
REQ-027 SHALL, in HOLD, commit shadow values to oCOS/oSIN/oANGLE on the first iFRAME_SYNC strictly after entering HOLD, pulse oUPDATED in the following cycle, and return to IDLE.
REQ-028 SHALL, when done and iFRAME_SYNC coincide in WAIT, defer the commit to the next iFRAME_SYNC.
REQ-029 SHALL keep the frame counter running in all FSM states.
REQ-030 SHALL, on a change of iAUTO mid-transaction, complete the transaction unchanged, then clear pending and reset the frame counter to 0.
REQ-031 SHALL drive oBUSY high in every state except IDLE.
REQ-032 SHALL dispatch a new request no sooner than the cycle after returning to IDLE.

Reset
REQ-033 SHALL, while RESET_N=0 at a clock edge, set state IDLE, oCOS=16'sh0100, oSIN=0, oANGLE=0, oCORDIC_ANGLE=0, all pulses, pending, frame counter and timeout counter to 0.
REQ-034 SHALL, on reset asserted mid-transaction, abandon the transaction and restore the reset values at the same edge.

Verification
REQ-035 SHALL cover manual mode: iAUTO=0, iTHETA=18, done 5 cycles after START with COS=0x0000, SIN=0x0100 -> one START with angle 18; commit at the next frame sync; oUPDATED 1 cycle; oANGLE=18.
REQ-036 SHALL cover auto-rotate wrap: iAUTO=1, iTHETA=10, oANGLE=65, 4 frame syncs -> target 4; pending coalesced if 8 syncs arrive during a single WAIT.
REQ-037 SHALL cover timeout: START issued, no done for 64 cycles -> oERR pulse at cycle 64; oCOS/oSIN/oANGLE unchanged; FSM in IDLE.
REQ-038 SHALL cover the coincidence case: done and iFRAME_SYNC in the same cycle -> no commit then; commit on the next sync.
REQ-039 SHALL cover clamping: iTHETA=75 in manual mode -> request angle 4.
REQ-040 SHALL cover reset during WAIT: RESET_N low one cycle -> oCOS=0x0100, oSIN=0, oBUSY=0; a later done pulse is ignored.

Source files
------------

// File: rtl/rotation_seq_ctrl_if.sv
// CORDIC request/response bundle for the rotation sequencer.
// master: controller (drives START/ANGLE); slave: CORDIC (drives DONE/COS/SIN).
interface rotation_seq_ctrl_if;
   logic               oCORDIC_START;
   logic [6:0]         oCORDIC_ANGLE;
   logic               iCORDIC_DONE;
   logic signed [15:0] iCORDIC_COS;
   logic signed [15:0] iCORDIC_SIN;

   modport master (
      output oCORDIC_START,
      output oCORDIC_ANGLE,
      input  iCORDIC_DONE,
      input  iCORDIC_COS,
      input  iCORDIC_SIN
   );

   modport slave (
      input  oCORDIC_START,
      input  oCORDIC_ANGLE,
      output iCORDIC_DONE,
      output iCORDIC_COS,
      output iCORDIC_SIN
   );
endinterface

// File: rtl/rotation_seq_ctrl.sv
// Rotation sequencer: requests cos/sin from a CORDIC and commits them on frame sync.
// Ports: CLK, RESET_N (sync), iAUTO/iTHETA/iFRAME_SYNC, cordic bundle, oCOS/oSIN/oANGLE, oBUSY/oUPDATED/oERR.
module rotation_seq_ctrl #(
   parameter int ANGLE_STEPS     = 71,
   parameter int FRAMES_PER_STEP = 4,
   parameter int TIMEOUT         = 64
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               iAUTO,
   input  logic [6:0]         iTHETA,
   input  logic               iFRAME_SYNC,
   rotation_seq_ctrl_if.master cordic,
   output logic signed [15:0] oCOS,
   output logic signed [15:0] oSIN,
   output logic [6:0]         oANGLE,
   output logic               oBUSY,
   output logic               oUPDATED,
   output logic               oERR
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [6:0] STEPS7 = 7'(ANGLE_STEPS);
   localparam logic [7:0] STEPS8 = 8'(ANGLE_STEPS);
   localparam logic [7:0] FLAST  = 8'(FRAMES_PER_STEP - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      HOLD
   } state_t;

   state_t             state_q, state_d;
   logic               mode_q;
   logic               pend_q;
   logic [7:0]         fcnt_q;
   logic [TW-1:0]      tcnt_q;
   logic [6:0]         ang_q;
   logic signed [15:0] cos_sh_q, sin_sh_q;

   logic [6:0] theta_n;
   logic [7:0] sum, sum_w;
   logic [6:0] auto_tgt;
   logic [6:0] target;
   logic       mode_chg, mode_sync, step_evt;
   logic       dispatch, clr_pend, capture, commit, timeout;

   assign theta_n  = (iTHETA >= STEPS7) ? iTHETA - STEPS7 : iTHETA;
   assign sum      = {1'b0, oANGLE} + {1'b0, theta_n};
   assign sum_w    = sum - STEPS8;
   assign auto_tgt = (sum >= STEPS8) ? sum_w[6:0] : sum[6:0];

   // A mode change is only acted on from IDLE, so an in-flight
   // transaction finishes with the mode it was started under.
   assign mode_chg  = (iAUTO != mode_q);
   assign mode_sync = (state_q == IDLE) && mode_chg;
   assign step_evt  = mode_q && iFRAME_SYNC && (fcnt_q == FLAST);

   always_comb begin
      state_d  = state_q;
      dispatch = 1'b0;
      clr_pend = 1'b0;
      capture  = 1'b0;
      commit   = 1'b0;
      timeout  = 1'b0;
      target   = theta_n;
      unique case (state_q)
         IDLE: begin
            if (!mode_chg) begin
               if (mode_q) begin
                  if (pend_q) begin
                     clr_pend = 1'b1;
                     if (theta_n != 7'd0) begin
                        dispatch = 1'b1;
                        target   = auto_tgt;
                     end
                  end
               end else if (theta_n != oANGLE) begin
                  dispatch = 1'b1;
               end
            end
            if (dispatch) state_d = START;
         end
         START: state_d = WAIT;
         WAIT: begin
            if (cordic.iCORDIC_DONE) begin
               capture = 1'b1;
               state_d = HOLD;
            end else if (tcnt_q >= TLAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         HOLD: begin
            // A sync coinciding with done lands in WAIT, so it never commits.
            if (iFRAME_SYNC) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         mode_q   <= 1'b0;
         pend_q   <= 1'b0;
         fcnt_q   <= '0;
         tcnt_q   <= '0;
         ang_q    <= '0;
         cos_sh_q <= '0;
         sin_sh_q <= '0;
         oCOS     <= 16'sh0100;
         oSIN     <= '0;
         oANGLE   <= '0;
         oUPDATED <= 1'b0;
         oERR     <= 1'b0;
      end else begin
         state_q  <= state_d;
         oUPDATED <= commit;
         oERR     <= timeout;

         if (mode_sync) begin
            mode_q <= iAUTO;
            fcnt_q <= '0;
            pend_q <= 1'b0;
         end else begin
            if (mode_q && iFRAME_SYNC)
               fcnt_q <= step_evt ? 8'd0 : fcnt_q + 8'd1;
            // Consume wins: an event while pending is set is coalesced.
            if (clr_pend)
               pend_q <= 1'b0;
            else if (step_evt)
               pend_q <= 1'b1;
         end

         if (dispatch) ang_q <= target;

         if (state_q == START)
            tcnt_q <= TW'(1);
         else if (state_q == WAIT)
            tcnt_q <= tcnt_q + TW'(1);

         if (capture) begin
            cos_sh_q <= cordic.iCORDIC_COS;
            sin_sh_q <= cordic.iCORDIC_SIN;
         end

         if (commit) begin
            oCOS   <= cos_sh_q;
            oSIN   <= sin_sh_q;
            oANGLE <= ang_q;
         end
      end
   end

   assign cordic.oCORDIC_START = (state_q == START);
   assign cordic.oCORDIC_ANGLE = ang_q;
   assign oBUSY                = (state_q != IDLE);

endmodule

// File: tb/tb_rotation_seq_ctrl.sv
// Directed bench for rotation_seq_ctrl.
// Drives frame syncs and CORDIC responses by hand; checks against fixed values.
module tb_rotation_seq_ctrl;

   logic               CLK = 1'b0;
   logic               RESET_N;
   logic               iAUTO;
   logic [6:0]         iTHETA;
   logic               iFRAME_SYNC;
   logic signed [15:0] oCOS, oSIN;
   logic [6:0]         oANGLE;
   logic               oBUSY, oUPDATED, oERR;

   int n_chk = 0;
   int n_err = 0;
   int starts = 0;

   always #5 CLK = ~CLK;

   rotation_seq_ctrl_if cif ();

   rotation_seq_ctrl dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .iAUTO       (iAUTO),
      .iTHETA      (iTHETA),
      .iFRAME_SYNC (iFRAME_SYNC),
      .cordic      (cif),
      .oCOS        (oCOS),
      .oSIN        (oSIN),
      .oANGLE      (oANGLE),
      .oBUSY       (oBUSY),
      .oUPDATED    (oUPDATED),
      .oERR        (oERR)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      starts += int'(cif.oCORDIC_START);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic sync();
      iFRAME_SYNC = 1'b1;
      tick();
      iFRAME_SYNC = 1'b0;
   endtask

   task automatic done(input logic [15:0] c, input logic [15:0] s);
      cif.iCORDIC_DONE = 1'b1;
      cif.iCORDIC_COS  = c;
      cif.iCORDIC_SIN  = s;
      tick();
      cif.iCORDIC_DONE = 1'b0;
   endtask

   initial begin
      RESET_N          = 1'b0;
      iAUTO            = 1'b0;
      iTHETA           = 7'd0;
      iFRAME_SYNC      = 1'b0;
      cif.iCORDIC_DONE = 1'b0;
      cif.iCORDIC_COS  = '0;
      cif.iCORDIC_SIN  = '0;
      run(2);
      chk("rst_cos", {16'h0, oCOS}, 32'h0100);
      chk("rst_sin", {16'h0, oSIN}, 32'h0);
      chk("rst_ang", oANGLE, 0);
      chk("rst_cang", cif.oCORDIC_ANGLE, 0);
      chk("rst_busy", oBUSY, 0);
      chk("rst_start", cif.oCORDIC_START, 0);
      chk("rst_upd", oUPDATED, 0);
      chk("rst_err", oERR, 0);
      RESET_N = 1'b1;
      tick();
      chk("idle_busy", oBUSY, 0);

      // manual request, done 5 cycles after START
      iTHETA = 7'd18;
      tick();
      chk("m_start", cif.oCORDIC_START, 1);
      chk("m_cang", cif.oCORDIC_ANGLE, 18);
      chk("m_busy", oBUSY, 1);
      starts = 0;
      run(5);
      chk("m_start_once", starts, 0);
      done(16'h0000, 16'h0100);
      chk("m_hold_upd", oUPDATED, 0);
      chk("m_hold_ang", oANGLE, 0);
      chk("m_hold_busy", oBUSY, 1);
      sync();
      chk("m_upd", oUPDATED, 1);
      chk("m_ang", oANGLE, 18);
      chk("m_cos", {16'h0, oCOS}, 32'h0000);
      chk("m_sin", {16'h0, oSIN}, 32'h0100);
      chk("m_idle", oBUSY, 0);
      tick();
      chk("m_upd_pulse", oUPDATED, 0);
      chk("m_no_redo", oBUSY, 0);

      // clamp 75 -> 4, then done coinciding with frame sync
      iTHETA = 7'd75;
      tick();
      chk("c_start", cif.oCORDIC_START, 1);
      chk("c_cang", cif.oCORDIC_ANGLE, 4);
      run(2);
      iFRAME_SYNC = 1'b1;
      done(16'h00F0, 16'h0040);
      iFRAME_SYNC = 1'b0;
      chk("co_no_upd", oUPDATED, 0);
      chk("co_no_ang", oANGLE, 18);
      run(2);
      chk("co_busy", oBUSY, 1);
      chk("co_ang_hold", oANGLE, 18);
      sync();
      chk("co_upd", oUPDATED, 1);
      chk("co_ang", oANGLE, 4);
      chk("co_cos", {16'h0, oCOS}, 32'h00F0);
      chk("co_sin", {16'h0, oSIN}, 32'h0040);

      // timeout: no done for 64 cycles after START
      iTHETA = 7'd30;
      tick();
      chk("t_start", cif.oCORDIC_START, 1);
      chk("t_cang", cif.oCORDIC_ANGLE, 30);
      iTHETA = 7'd4;
      run(63);
      chk("t_err_early", oERR, 0);
      chk("t_busy63", oBUSY, 1);
      tick();
      chk("t_err", oERR, 1);
      chk("t_idle", oBUSY, 0);
      chk("t_ang", oANGLE, 4);
      chk("t_cos", {16'h0, oCOS}, 32'h00F0);
      chk("t_sin", {16'h0, oSIN}, 32'h0040);
      tick();
      chk("t_err_pulse", oERR, 0);

      // move to 65 manually, then auto step 10 -> wraps to 4
      iTHETA = 7'd65;
      tick();
      chk("a_pre_cang", cif.oCORDIC_ANGLE, 65);
      run(1);
      done(16'hFF80, 16'h00C0);
      sync();
      chk("a_pre_ang", oANGLE, 65);
      iAUTO  = 1'b1;
      iTHETA = 7'd10;
      tick();
      starts = 0;
      repeat (3) begin
         sync();
         tick();
      end
      chk("a_3sync_idle", oBUSY, 0);
      chk("a_3sync_nost", starts, 0);
      sync();
      tick();
      chk("a_start", cif.oCORDIC_START, 1);
      chk("a_wrap_tgt", cif.oCORDIC_ANGLE, 4);
      repeat (8) begin
         sync();
         tick();
      end
      chk("a_wait_busy", oBUSY, 1);
      done(16'h0100, 16'h0000);
      sync();
      chk("a_upd", oUPDATED, 1);
      chk("a_ang", oANGLE, 4);
      tick();
      chk("a_pend_start", cif.oCORDIC_START, 1);
      chk("a_pend_tgt", cif.oCORDIC_ANGLE, 14);
      run(1);
      done(16'h00B5, 16'h00B5);
      sync();
      chk("a2_ang", oANGLE, 14);
      starts = 0;
      run(4);
      chk("a_coalesce", starts, 0);
      chk("a_idle", oBUSY, 0);

      // step size 0: event consumed, nothing dispatched
      iTHETA = 7'd0;
      sync();
      tick();
      sync();
      tick();
      starts = 0;
      run(3);
      chk("z_nost", starts, 0);
      chk("z_ang", oANGLE, 14);
      iTHETA = 7'd10;
      run(3);
      chk("z_pend_clr", starts, 0);

      // reset in WAIT, late done ignored
      iAUTO  = 1'b0;
      iTHETA = 7'd20;
      run(2);
      chk("r_start", cif.oCORDIC_START, 1);
      chk("r_cang", cif.oCORDIC_ANGLE, 20);
      run(2);
      RESET_N = 1'b0;
      iTHETA  = 7'd0;
      tick();
      RESET_N = 1'b1;
      chk("r_cos", {16'h0, oCOS}, 32'h0100);
      chk("r_sin", {16'h0, oSIN}, 32'h0);
      chk("r_busy", oBUSY, 0);
      chk("r_ang", oANGLE, 0);
      chk("r_cang0", cif.oCORDIC_ANGLE, 0);
      done(16'h1234, 16'h1234);
      sync();
      run(2);
      chk("r_late_cos", {16'h0, oCOS}, 32'h0100);
      chk("r_late_busy", oBUSY, 0);
      chk("r_late_upd", oUPDATED, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
